// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - token/state types, precedence and ALU helpers for the expression evaluator
package expr_pkg;

  typedef enum logic [2:0] {
    TOK_NUM  = 3'd0,
    TOK_ADD  = 3'd1,
    TOK_SUB  = 3'd2,
    TOK_MUL  = 3'd3,
    TOK_LPAR = 3'd4,
    TOK_RPAR = 3'd5,
    TOK_END  = 3'd6
  } tok_t;

  // Operator-stack entries reuse the token encoding (ADD/SUB/MUL/LPAR).
  localparam int OP_W    = 3;
  localparam int NUM_MAX = 63;

  typedef enum logic [2:0] {
    ST_ACCEPT,
    ST_REDUCE_OP,
    ST_REDUCE_PAR,
    ST_REDUCE_END,
    ST_DONE,
    ST_DRAIN
  } state_t;

  function automatic logic [1:0] prec(input logic [2:0] op);
    case (op)
      TOK_MUL:          prec = 2'd2;
      TOK_ADD, TOK_SUB: prec = 2'd1;
      default:          prec = 2'd0;
    endcase
  endfunction

  // Low 32 bits of a product are identical for signed and unsigned operands.
  function automatic logic [31:0] alu(input logic [31:0] second, input logic [2:0] op,
                                      input logic [31:0] top);
    case (op)
      TOK_ADD: alu = second + top;
      TOK_SUB: alu = second - top;
      TOK_MUL: alu = second * top;
      default: alu = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/op_stack.sv
// rtl/op_stack.sv - small LIFO holding pending operators and open parentheses
module op_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW-1:0] top_idx;

  assign top_idx = cnt[AW-1:0] - 1'b1;
  assign top     = mem[top_idx];
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem[cnt[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/expr_eval_ctrl.sv
// rtl/expr_eval_ctrl.sv - shunting-yard evaluation controller driving the number stack
module expr_eval_ctrl #(
  parameter int OP_DEPTH = 16,
  parameter int NUM_MAX  = expr_pkg::NUM_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic [2:0]  tok_type,
  input  logic [31:0] tok_data,
  output logic        ns_push,
  output logic        ns_pop2,
  output logic        ns_flush,
  output logic [31:0] ns_wdata,
  input  logic [31:0] ns_top,
  input  logic [31:0] ns_second,
  input  logic        ns_empty,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err
);

  import expr_pkg::*;

  localparam int               CNT_W   = $clog2(NUM_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_cnt;
  logic [OP_W-1:0]  op_top;
  logic             op_empty, op_full, op_push, op_pop, op_flush;
  logic             is_op, hold_op, can_reduce, top_is_lpar, end_ok;
  logic             reduce_want, do_reduce;

  op_stack #(.DEPTH(OP_DEPTH), .W(OP_W)) u_op_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (op_push),
    .pop   (op_pop),
    .flush (op_flush),
    .din   (tok_type),
    .top   (op_top),
    .empty (op_empty),
    .full  (op_full)
  );

  assign is_op       = (tok_type == TOK_ADD) || (tok_type == TOK_SUB) || (tok_type == TOK_MUL);
  // LPAR has precedence 0, so it never satisfies the hold condition for a real operator.
  assign hold_op     = !op_empty && (prec(op_top) >= prec(tok_type));
  assign can_reduce  = (num_cnt >= CNT_W'(2)) && !ns_empty;
  assign top_is_lpar = !op_empty && (op_top == TOK_LPAR);
  assign end_ok      = op_empty && (num_cnt == CNT_W'(1));

  always_comb begin
    reduce_want = 1'b0;
    case (state)
      ST_REDUCE_OP:                 reduce_want = hold_op;
      ST_REDUCE_PAR, ST_REDUCE_END: reduce_want = !op_empty && !top_is_lpar;
      default:                      reduce_want = 1'b0;
    endcase
  end

  assign do_reduce = reduce_want && can_reduce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ACCEPT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCEPT: begin
        if (tok_valid) begin
          case (tok_type)
            TOK_NUM:                   if (num_cnt == CNT_MAX) state_nxt = ST_DRAIN;
            TOK_ADD, TOK_SUB, TOK_MUL: begin
              if (hold_op)      state_nxt = ST_REDUCE_OP;
              else if (op_full) state_nxt = ST_DRAIN;
            end
            TOK_LPAR:                  if (op_full) state_nxt = ST_DRAIN;
            TOK_RPAR:                  state_nxt = ST_REDUCE_PAR;
            TOK_END:                   state_nxt = ST_REDUCE_END;
            default:                   state_nxt = ST_DRAIN;
          endcase
        end
      end
      ST_REDUCE_OP: begin
        if (!hold_op)         state_nxt = ST_ACCEPT;
        else if (!can_reduce) state_nxt = ST_DRAIN;
      end
      ST_REDUCE_PAR: begin
        if (op_empty)         state_nxt = ST_DRAIN;
        else if (top_is_lpar) state_nxt = ST_ACCEPT;
        else if (!can_reduce) state_nxt = ST_DRAIN;
      end
      // END is already consumed here, so any failure reports directly instead of draining.
      ST_REDUCE_END: if (!do_reduce) state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_ACCEPT;
      ST_DRAIN:      if (tok_valid && (tok_type == TOK_END)) state_nxt = ST_DONE;
      default:       state_nxt = ST_ACCEPT;
    endcase
  end

  always_comb begin
    tok_ready = 1'b0;
    ns_push   = 1'b0;
    ns_pop2   = 1'b0;
    ns_flush  = 1'b0;
    ns_wdata  = 32'd0;
    op_push   = 1'b0;
    op_pop    = 1'b0;
    op_flush  = 1'b0;
    case (state)
      ST_ACCEPT: begin
        tok_ready = !(is_op && hold_op);
        if (tok_valid) begin
          if (tok_type == TOK_NUM && num_cnt != CNT_MAX) begin
            ns_push  = 1'b1;
            ns_wdata = tok_data;
          end
          if ((is_op && !hold_op && !op_full) || (tok_type == TOK_LPAR && !op_full)) begin
            op_push = 1'b1;
          end
        end
      end
      ST_REDUCE_OP, ST_REDUCE_PAR, ST_REDUCE_END: begin
        if (do_reduce) begin
          ns_push  = 1'b1;
          ns_pop2  = 1'b1;
          ns_wdata = alu(ns_second, op_top, ns_top);
          op_pop   = 1'b1;
        end
        if (state == ST_REDUCE_PAR && top_is_lpar) op_pop = 1'b1;
      end
      ST_DONE: begin
        ns_flush = 1'b1;
        op_flush = 1'b1;
      end
      ST_DRAIN: tok_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_cnt <= '0;
    end else if (state == ST_DONE) begin
      num_cnt <= '0;
    end else if (ns_push && ns_pop2) begin
      num_cnt <= num_cnt - 1'b1;
    end else if (ns_push) begin
      num_cnt <= num_cnt + 1'b1;
    end
  end

  // Result is captured on entry to DONE so res_valid lines up with ns_flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_data  <= 32'd0;
    end else if (state_nxt == ST_DONE && state != ST_DONE) begin
      res_valid <= 1'b1;
      res_err   <= !(state == ST_REDUCE_END && end_ok);
      res_data  <= (state == ST_REDUCE_END && end_ok) ? ns_top : 32'd0;
    end else begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_data  <= 32'd0;
    end
  end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// tb/tb_expr_eval_ctrl.sv - scoreboard bench for expr_eval_ctrl with a number-stack model
module tb_expr_eval_ctrl;
  import expr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tok_valid, tok_ready;
  logic [2:0]  tok_type;
  logic [31:0] tok_data;
  logic        ns_push, ns_pop2, ns_flush;
  logic [31:0] ns_wdata, ns_top, ns_second;
  logic        ns_empty;
  logic        res_valid, res_err;
  logic [31:0] res_data;

  typedef struct { logic [2:0] t; logic [31:0] d; } tok_s;
  typedef struct { logic err; logic [31:0] data; } res_s;

  tok_s tq[$];
  res_s exp_q[$];
  res_s mon_e;
  int   total = 0, bad = 0, results_seen = 0;
  int   pop2_cnt = 0, flush_cnt = 0, stall_cnt = 0;

  logic [31:0] stk [0:71];
  int          sp;

  always #5 clk = ~clk;

  expr_eval_ctrl #(.OP_DEPTH(16), .NUM_MAX(63)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_data(tok_data),
    .ns_push(ns_push), .ns_pop2(ns_pop2), .ns_flush(ns_flush), .ns_wdata(ns_wdata),
    .ns_top(ns_top), .ns_second(ns_second), .ns_empty(ns_empty),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err)
  );

  // Number stack stand-in, reset by the same rst.
  always @(posedge clk or posedge rst) begin
    if (rst) sp <= 0;
    else if (ns_flush) sp <= 0;
    else if (ns_push && ns_pop2 && sp >= 2) begin
      stk[sp-2] <= ns_wdata;
      sp <= sp - 1;
    end else if (ns_push && sp < 72) begin
      stk[sp] <= ns_wdata;
      sp <= sp + 1;
    end
  end

  assign ns_top    = (sp >= 1) ? stk[sp-1] : 32'd0;
  assign ns_second = (sp >= 2) ? stk[sp-2] : 32'd0;
  assign ns_empty  = (sp == 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ns_push && ns_pop2) pop2_cnt++;
      if (ns_flush) flush_cnt++;
      if (tok_valid && !tok_ready) stall_cnt++;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("res_without_expect", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_err", 64'(res_err), 64'(mon_e.err));
          check("res_data", 64'(res_data), 64'(mon_e.data));
        end
        results_seen++;
      end
    end
  end

  task automatic num(input logic [31:0] v);
    tok_s x;
    x.t = TOK_NUM;
    x.d = v;
    tq.push_back(x);
  endtask

  task automatic op(input logic [2:0] t);
    tok_s x;
    x.t = t;
    x.d = 32'd0;
    tq.push_back(x);
  endtask

  task automatic send_tok(input logic [2:0] t, input logic [31:0] d);
    int n;
    n = 0;
    tok_valid = 1'b1;
    tok_type  = t;
    tok_data  = d;
    @(negedge clk);
    while (!tok_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!tok_ready) check("tok_ready_timeout", 64'(tok_ready), 64'd1);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
  endtask

  task automatic send_all();
    tok_s x;
    while (tq.size() > 0) begin
      x = tq.pop_front();
      send_tok(x.t, x.d);
    end
  endtask

  task automatic run(input string tag, input logic err, input logic [31:0] data, input int exp_pop2);
    res_s r;
    int   target, n;
    r.err = err;
    r.data = data;
    exp_q.push_back(r);
    pop2_cnt = 0;
    flush_cnt = 0;
    stall_cnt = 0;
    target = results_seen + 1;
    send_all();
    n = 0;
    while (results_seen < target && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_result_seen"}, 64'(results_seen >= target), 64'd1);
    if (exp_pop2 >= 0) check({tag, "_pop2"}, 64'(pop2_cnt), 64'(exp_pop2));
    check({tag, "_flush"}, 64'(flush_cnt), 64'd1);
    check({tag, "_stack_empty"}, 64'(sp), 64'd0);
  endtask

  function automatic logic [31:0] ev(input logic [31:0] a, input logic [2:0] o, input logic [31:0] b);
    if (o == TOK_ADD) return a + b;
    if (o == TOK_SUB) return a - b;
    return a * b;
  endfunction

  initial begin
    logic [31:0] a, b, c, e;
    logic [2:0]  o1, o2;
    rst = 1'b1;
    tok_valid = 1'b0;
    tok_type = 3'd0;
    tok_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_ns_strobes", 64'({ns_push, ns_pop2, ns_flush}), 64'd0);
    check("rst_tok_ready", 64'(tok_ready), 64'd1);
    @(posedge clk);
    #1;

    num(3); op(TOK_ADD); num(4); op(TOK_MUL); num(2); op(TOK_END);
    run("prec", 1'b0, 32'd11, 2);

    op(TOK_LPAR); num(3); op(TOK_ADD); num(4); op(TOK_RPAR); op(TOK_MUL); num(2); op(TOK_END);
    run("paren", 1'b0, 32'd14, 2);

    num(10); op(TOK_SUB); num(3); op(TOK_SUB); num(2); op(TOK_END);
    run("leftassoc", 1'b0, 32'd5, 2);
    check("sub_stalled", 64'(stall_cnt > 0), 64'd1);

    num(32'h7FFF_FFFF); op(TOK_ADD); num(32'd1); op(TOK_END);
    run("add_wrap", 1'b0, 32'h8000_0000, 1);

    num(32'h1_0000); op(TOK_MUL); num(32'h1_0000); op(TOK_END);
    run("mul_wrap", 1'b0, 32'd0, 1);

    num(3); op(TOK_RPAR); num(4); op(TOK_END);
    run("bad_rpar", 1'b1, 32'd0, -1);

    num(2); op(TOK_MUL); num(5); op(TOK_END);
    run("after_err", 1'b0, 32'd10, 1);

    op(TOK_END);
    run("empty_expr", 1'b1, 32'd0, -1);

    op(TOK_LPAR); num(1); op(TOK_ADD); num(2); op(TOK_END);
    run("open_lpar", 1'b1, 32'd0, -1);

    for (int i = 1; i <= 64; i++) num(32'(i));
    op(TOK_END);
    run("num_overflow", 1'b1, 32'd0, -1);

    for (int i = 0; i < 17; i++) op(TOK_LPAR);
    op(TOK_END);
    run("op_overflow", 1'b1, 32'd0, -1);

    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      o1 = 3'($urandom_range(1, 3));
      o2 = 3'($urandom_range(1, 3));
      if (o2 == TOK_MUL && o1 != TOK_MUL) e = ev(a, o1, ev(b, o2, c));
      else e = ev(ev(a, o1, b), o2, c);
      num(a); op(o1); num(b); op(o2); num(c); op(TOK_END);
      run("rand", 1'b0, e, 2);
    end

    num(7); op(TOK_ADD);
    send_all();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_res", 64'({res_valid, res_err, res_data}), 64'd0);
    check("midrst_ns", 64'({ns_push, ns_pop2, ns_flush}), 64'd0);
    check("midrst_stack", 64'(sp), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(tok_ready), 64'd1);
    @(posedge clk);
    #1;
    num(1); op(TOK_ADD); num(1); op(TOK_END);
    run("post_rst", 1'b0, 32'd2, 1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
